ysyx_22050598_axi_rd_arbiter: RTL and testbench
===============================================

# ysyx_22050598_axi_rd_arbiter

Two-master AXI4 read arbiter between the core's instruction fetch unit (M0) and load/store unit (M1) and the single memory-side AXI slave port. It serialises read bursts with a grant held from address handshake to last beat. The LSU write channels pass straight through to the slave. It sits between the IFU/LSU AXI masters and the memory slave.

## Interface
- `ID_W`, default 1: AXI ID width.
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width.

Ports:
- `ACLK`  in  1  clock.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `m0_ar*` / `m1_ar*`  (master side, in/out)  standard AR bundle:
  - `arid` ID_W, `araddr` ADDR_W, `arlen` 8, `arsize` 3, `arburst` 2, `arcache` 4, `arprot` 3, `arqos` 4, `arvalid` in.
  - `arready` out.
- `m0_r*` / `m1_r*`  (master side, in/out)  R bundle:
  - `rid`, `rdata`, `rresp`, `rlast`, `rvalid` out.
  - `rready` in.
- `s_ar*` / `s_r*`  (slave side)  the same bundles, directions mirrored.
- `m1_aw*`, `m1_w*`, `m1_b*` ↔ `s_aw*`, `s_w*`, `s_b*`: full write bundles, combinational pass-through.
- `gnt`  out  2: one-hot current owner. Bit 0 = M0, bit 1 = M1. Zero in IDLE.

## Operation
- FSM states: IDLE, ADDR_M0, ADDR_M1, DATA_M0, DATA_M1. Reset state is IDLE.
- **IDLE**
  - Evaluate `m0_arvalid` and `m1_arvalid`.
  - Choose a winner by the priority rule (see Configuration) and go to ADDR_Mx next cycle.
  - If neither is requesting, stay in IDLE.
  - All `arready` are 0 and `s_arvalid` is 0.
- **ADDR_Mx**
  - `s_ar*` = `mx_ar*`.
  - `mx_arready` = `s_arready`.
  - The other master's `arready` is 0.
  - When `mx_arvalid` & `s_arready` are both high, go to DATA_Mx.
- **DATA_Mx**
  - `mx_r*` = `s_r*`.
  - `s_rready` = `mx_rready`.
  - The other master sees `rvalid` = 0.
  - `s_arvalid` is 0.
  - On `s_rvalid` & `mx_rready` & `s_rlast`, go to IDLE. The `last_gnt` register is updated to x.
- **Ungranted master**
  - Its `arready` is 0 and its `rvalid` is 0.
  - Its `rdata`/`rid`/`rresp`/`rlast` are driven to 0.
- **Stray beats:** a slave R beat arriving in IDLE or ADDR_x gets `s_rready` = 0 (held off, never dropped).
- **Write path:** purely combinational. It is independent of the read FSM and of `gnt`. Read/write ordering is the LSU's responsibility.
- **Mid-burst requests:** requests arriving during DATA_x are not sampled until IDLE. One read burst is outstanding at a time.

## Timing
- Arbitration latency: one cycle.
  - A request seen in IDLE at cycle N → `s_arvalid` high at N+1.
  - Minimum AR acceptance is N+1.
- Back-to-back bursts cost one IDLE cycle between the RLAST handshake and the next ADDR state.
- Handshake rules:
  - `mx_arvalid` must not drop in ADDR_x before the handshake (AXI rule). The arbiter does not re-arbitrate inside ADDR_x.
  - A master that deasserts `arvalid` illegally leaves the FSM in ADDR_x; no timeout.
- Reset (asynchronous, any time, including mid-burst):
  - FSM → IDLE, `last_gnt` → M1 (so M0 wins the first RR tie), `gnt` → 0.
  - All master `arready`/`rvalid` → 0.
  - `s_arvalid` → 0, `s_rready` → 0.
  - Write-path outputs follow their inputs.
- Single-beat bursts (`arlen` = 0): `rlast` is on the first beat, and DATA_x lasts one handshake cycle.
- `s_rready` low stalls DATA_x indefinitely; the grant is held.

## Configuration
- `YSYX_22050598_ARB_RR_EN`
  - **Defined:** round-robin. On a simultaneous request in IDLE, the master not equal to `last_gnt` wins. A single requester always wins.
  - **Undefined:** fixed priority. M1 (LSU) wins every simultaneous request, and `last_gnt` is unused (optimised away).

## Test plan
- M0 only, `araddr` = 0x8000_0000, `arlen` = 1:
  - `s_arvalid` rises 1 cycle after `m0_arvalid`.
  - Two beats are routed to M0 with `rlast` on beat 2.
  - `gnt` goes 01 → 00 after the last beat.
  - M1 sees `rvalid` = 0 throughout.
- M0 and M1 request in the same cycle, repeated 4 times with `arlen` = 0:
  - RR_EN defined → grant order M0, M1, M0, M1.
  - Undefined → M1 each time while both hold requests.
- M1 raises `arvalid` during an M0 `arlen` = 1 burst with `m0_rready` toggling 1,0,1:
  - M1 stays at `arready` = 0 until M0's last beat completes.
  - M1 is granted after one IDLE cycle.
  - No beat is lost or duplicated.
- `ARESETN` pulsed low during DATA_M1 beat 1:
  - All outputs hit reset values asynchronously, and `gnt` = 00.
  - After release, an M0 request is granted in 1 cycle.
- M1 write (`awaddr` = 0x8000_0100, `wdata` = 0xDEAD_BEEF_0000_0001, `wstrb` = 0xFF, `wlast` = 1) concurrent with an M0 read:
  - `s_aw`/`s_w`/`s_b` mirror M1 in the same cycle.
  - The M0 read completes unaffected.
- Slave delays `s_arready` 3 cycles in ADDR_M1:
  - `m1_arready` mirrors it.
  - `s_ar*` stays stable.
  - No switch to M0 despite `m0_arvalid` = 1.

Source files
------------

// File: rtl/ysyx_22050598_axi_rd_arbiter_if.sv
// AXI4 bundles used by the IFU/LSU read arbiter.
//   ysyx_22050598_axi_rd_arbiter_if    : AR + R channels (one read port)
//   ysyx_22050598_axi_rd_arbiter_wr_if : AW + W + B channels (one write port)
// "master" is the side that issues requests, "slave" the side that answers.

interface ysyx_22050598_axi_rd_arbiter_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // read address channel
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  // read data channel
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos, arvalid,
    output rready,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos, arvalid,
    input  rready,
    output arready,
    output rid, rdata, rresp, rlast, rvalid
  );
endinterface

interface ysyx_22050598_axi_rd_arbiter_wr_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // write address channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  // write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // write response channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready,
    input  bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awqos, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready,
    output bid, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_22050598_axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: M0 = IFU, M1 = LSU, one memory slave port.
// A grant is held from the AR handshake until the RLAST handshake, so only one
// read burst is ever outstanding. The LSU write channels are wired straight
// through to the slave and never interact with the read FSM.
//
// Optional feature macro: YSYX_22050598_ARB_RR_EN
//   defined   -> round-robin on simultaneous requests (last owner loses the tie)
//   undefined -> fixed priority, M1 (LSU) wins every tie

module ysyx_22050598_axi_rd_arbiter #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  ysyx_22050598_axi_rd_arbiter_if.slave        m0,
  ysyx_22050598_axi_rd_arbiter_if.slave        m1,
  ysyx_22050598_axi_rd_arbiter_if.master       s,
  ysyx_22050598_axi_rd_arbiter_wr_if.slave     m1_wr,
  ysyx_22050598_axi_rd_arbiter_wr_if.master    s_wr,
  output logic [1:0]                           gnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_M0 = 3'd1,
    ADDR_M1 = 3'd2,
    DATA_M0 = 3'd3,
    DATA_M1 = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_any_req;      // at least one master presents arvalid
  logic w_pick_m1;      // arbitration result in IDLE
  logic w_addr_phase;   // ADDR_M0 or ADDR_M1
  logic w_data_phase;   // DATA_M0 or DATA_M1
  logic w_own_m1;       // current owner is M1 (only meaningful outside IDLE)
  logic w_own_rready;   // rready of the current owner
  logic w_rd_done;      // RLAST handshake of the granted burst

  // AR fields of the current owner, before gating by the address phase
  logic [ID_W-1:0]   w_ar_id;
  logic [ADDR_W-1:0] w_ar_addr;
  logic [7:0]        w_ar_len;
  logic [2:0]        w_ar_size;
  logic [1:0]        w_ar_burst;
  logic [3:0]        w_ar_cache;
  logic [2:0]        w_ar_prot;
  logic [3:0]        w_ar_qos;
  logic              w_ar_valid;

  // slave R fields, fanned out to whichever master owns the data phase
  logic [ID_W-1:0]   w_r_id;
  logic [DATA_W-1:0] w_r_data;
  logic [1:0]        w_r_resp;
  logic              w_r_last;
  logic              w_r_valid;

  assign w_any_req    = m0.arvalid | m1.arvalid;
  assign w_addr_phase = (r_state == ADDR_M0) || (r_state == ADDR_M1);
  assign w_data_phase = (r_state == DATA_M0) || (r_state == DATA_M1);
  assign w_own_m1     = (r_state == ADDR_M1) || (r_state == DATA_M1);
  assign w_own_rready = w_own_m1 ? m1.rready : m0.rready;
  assign w_rd_done    = w_data_phase & s.rvalid & s.rready & s.rlast;

`ifdef YSYX_22050598_ARB_RR_EN
  // 0 = M0 was the last owner, 1 = M1; reset to M1 so M0 wins the first tie
  logic r_last_gnt;

  // Remember who finished the most recent burst, for the next tie-break
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_last_gnt <= 1'b1;
    end else if (w_rd_done) begin
      r_last_gnt <= (r_state == DATA_M1);
    end
  end

  // M1 wins alone, or on a tie when M0 owned the bus last
  assign w_pick_m1 = m1.arvalid & (~m0.arvalid | ~r_last_gnt);
`else
  // LSU requests always beat instruction fetch
  assign w_pick_m1 = m1.arvalid;
`endif

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant until the RLAST handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_next = w_pick_m1 ? ADDR_M1 : ADDR_M0;
        end
      end
      ADDR_M0: begin
        if (m0.arvalid && s.arready) begin
          w_state_next = DATA_M0;
        end
      end
      ADDR_M1: begin
        if (m1.arvalid && s.arready) begin
          w_state_next = DATA_M1;
        end
      end
      DATA_M0, DATA_M1: begin
        if (w_rd_done) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Select the owner's AR bundle
  assign w_ar_id    = w_own_m1 ? m1.arid    : m0.arid;
  assign w_ar_addr  = w_own_m1 ? m1.araddr  : m0.araddr;
  assign w_ar_len   = w_own_m1 ? m1.arlen   : m0.arlen;
  assign w_ar_size  = w_own_m1 ? m1.arsize  : m0.arsize;
  assign w_ar_burst = w_own_m1 ? m1.arburst : m0.arburst;
  assign w_ar_cache = w_own_m1 ? m1.arcache : m0.arcache;
  assign w_ar_prot  = w_own_m1 ? m1.arprot  : m0.arprot;
  assign w_ar_qos   = w_own_m1 ? m1.arqos   : m0.arqos;
  assign w_ar_valid = w_own_m1 ? m1.arvalid : m0.arvalid;

  // Drive the slave AR channel only while an address phase is in progress
  always_comb begin
    s.arid    = '0;
    s.araddr  = '0;
    s.arlen   = '0;
    s.arsize  = '0;
    s.arburst = '0;
    s.arcache = '0;
    s.arprot  = '0;
    s.arqos   = '0;
    s.arvalid = 1'b0;
    if (w_addr_phase) begin
      s.arid    = w_ar_id;
      s.araddr  = w_ar_addr;
      s.arlen   = w_ar_len;
      s.arsize  = w_ar_size;
      s.arburst = w_ar_burst;
      s.arcache = w_ar_cache;
      s.arprot  = w_ar_prot;
      s.arqos   = w_ar_qos;
      s.arvalid = w_ar_valid;
    end
  end

  // Only the owner in its address phase sees the slave's arready
  always_comb begin
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    if (r_state == ADDR_M0) begin
      m0.arready = s.arready;
    end
    if (r_state == ADDR_M1) begin
      m1.arready = s.arready;
    end
  end

  assign w_r_id    = s.rid;
  assign w_r_data  = s.rdata;
  assign w_r_resp  = s.rresp;
  assign w_r_last  = s.rlast;
  assign w_r_valid = s.rvalid;

  // Route R beats to the owner; stray beats outside a data phase are held off
  always_comb begin
    m0.rid    = '0;
    m0.rdata  = '0;
    m0.rresp  = '0;
    m0.rlast  = 1'b0;
    m0.rvalid = 1'b0;
    m1.rid    = '0;
    m1.rdata  = '0;
    m1.rresp  = '0;
    m1.rlast  = 1'b0;
    m1.rvalid = 1'b0;
    s.rready  = 1'b0;
    if (r_state == DATA_M0) begin
      m0.rid    = w_r_id;
      m0.rdata  = w_r_data;
      m0.rresp  = w_r_resp;
      m0.rlast  = w_r_last;
      m0.rvalid = w_r_valid;
      s.rready  = w_own_rready;
    end
    if (r_state == DATA_M1) begin
      m1.rid    = w_r_id;
      m1.rdata  = w_r_data;
      m1.rresp  = w_r_resp;
      m1.rlast  = w_r_last;
      m1.rvalid = w_r_valid;
      s.rready  = w_own_rready;
    end
  end

  // One-hot owner indication, zero while idle
  always_comb begin
    gnt = 2'b00;
    case (r_state)
      ADDR_M0, DATA_M0: gnt = 2'b01;
      ADDR_M1, DATA_M1: gnt = 2'b10;
      default:          gnt = 2'b00;
    endcase
  end

  // LSU write path: pure wires, independent of the read grant
  assign s_wr.awid    = m1_wr.awid;
  assign s_wr.awaddr  = m1_wr.awaddr;
  assign s_wr.awlen   = m1_wr.awlen;
  assign s_wr.awsize  = m1_wr.awsize;
  assign s_wr.awburst = m1_wr.awburst;
  assign s_wr.awcache = m1_wr.awcache;
  assign s_wr.awprot  = m1_wr.awprot;
  assign s_wr.awqos   = m1_wr.awqos;
  assign s_wr.awvalid = m1_wr.awvalid;
  assign m1_wr.awready = s_wr.awready;

  assign s_wr.wdata   = m1_wr.wdata;
  assign s_wr.wstrb   = m1_wr.wstrb;
  assign s_wr.wlast   = m1_wr.wlast;
  assign s_wr.wvalid  = m1_wr.wvalid;
  assign m1_wr.wready = s_wr.wready;

  assign m1_wr.bid    = s_wr.bid;
  assign m1_wr.bresp  = s_wr.bresp;
  assign m1_wr.bvalid = s_wr.bvalid;
  assign s_wr.bready  = m1_wr.bready;

endmodule

// File: tb/tb_ysyx_22050598_axi_rd_arbiter.sv
// Self-checking bench for ysyx_22050598_axi_rd_arbiter.
// The reference model tracks which masters hold a pending read request and
// who owned the bus last, and picks winners straight from the arbitration rule.
module tb_ysyx_22050598_axi_rd_arbiter;
  localparam int ID_W   = 1;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [1:0] gnt;

  ysyx_22050598_axi_rd_arbiter_if    #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  ysyx_22050598_axi_rd_arbiter_if    #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  ysyx_22050598_axi_rd_arbiter_if    #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();
  ysyx_22050598_axi_rd_arbiter_wr_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1w_if ();
  ysyx_22050598_axi_rd_arbiter_wr_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sw_if ();

  ysyx_22050598_axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .m1_wr   (m1w_if),
    .s_wr    (sw_if),
    .gnt     (gnt)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;

  // reference model: pending requests per master and the last owner
  bit          pend [2];
  logic [63:0] paddr [2];
  logic [7:0]  plen [2];
  logic        pid [2];
  int          last_w = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (pend[0] && !pend[1]) return 0;
    if (pend[1] && !pend[0]) return 1;
`ifdef YSYX_22050598_ARB_RR_EN
    return (last_w == 1) ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic new_req(input int m);
    pend[m]  = 1'b1;
    paddr[m] = {$urandom, $urandom};
    plen[m]  = 8'($urandom_range(0, 3));
    pid[m]   = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_ar();
    m0_if.arvalid = pend[0];
    m0_if.araddr  = paddr[0];
    m0_if.arlen   = plen[0];
    m0_if.arid    = pid[0];
    m1_if.arvalid = pend[1];
    m1_if.araddr  = paddr[1];
    m1_if.arlen   = plen[1];
    m1_if.arid    = pid[1];
  endtask

  // One arbitration round starting at a negedge with the DUT in IDLE.
  task automatic do_round(input bit allow_new, input int ar_dly);
    int w, l, d, cnt, it, lenw;
    logic rv, rr, lr, rl;
    logic [63:0] dat, wa, wd;
    logic [1:0] rs;
    if (allow_new) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1) new_req(m);
    end
    if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
    drive_ar();
    s_if.rvalid = 1'b1;
    s_if.rlast = 1'b0;
    m0_if.rready = 1'b1;
    m1_if.rready = 1'b1;
    s_if.arready = 1'($urandom_range(0, 1));
    #1;
    chk("idle_gnt", 64'(gnt), 64'd0);
    chk("idle_s_arvalid", 64'(s_if.arvalid), 64'd0);
    chk("idle_m0_arready", 64'(m0_if.arready), 64'd0);
    chk("idle_m1_arready", 64'(m1_if.arready), 64'd0);
    chk("idle_stray_rready", 64'(s_if.rready), 64'd0);
    chk("idle_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
    chk("idle_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
    w = pick();
    l = 1 - w;
    lenw = int'(plen[w]);
    @(negedge ACLK);
    d = (ar_dly < 0) ? int'($urandom_range(0, 2)) : ar_dly;
    for (int i = 0; i <= d; i++) begin
      s_if.arready = (i == d);
      #1;
      chk("addr_gnt", 64'(gnt), (w == 1) ? 64'd2 : 64'd1);
      chk("addr_s_arvalid", 64'(s_if.arvalid), 64'd1);
      chk("addr_s_araddr", s_if.araddr, paddr[w]);
      chk("addr_s_arlen", 64'(s_if.arlen), 64'(plen[w]));
      chk("addr_s_arid", 64'(s_if.arid), 64'(pid[w]));
      chk("addr_s_arsize", 64'(s_if.arsize), (w == 1) ? 64'd3 : 64'd2);
      chk("addr_win_arready", 64'((w == 1) ? m1_if.arready : m0_if.arready), 64'(i == d));
      chk("addr_lose_arready", 64'((l == 1) ? m1_if.arready : m0_if.arready), 64'd0);
      chk("addr_stray_rready", 64'(s_if.rready), 64'd0);
      @(negedge ACLK);
    end
    pend[w] = 1'b0;
    drive_ar();
    s_if.arready = 1'b0;
    cnt = 0;
    it = 0;
    while (cnt <= lenw && it < 200) begin
      it++;
      rv  = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      lr  = 1'($urandom_range(0, 1));
      dat = {$urandom, $urandom};
      rs  = 2'($urandom_range(0, 3));
      rl  = (cnt == lenw);
      s_if.rvalid = rv;
      s_if.rdata  = dat;
      s_if.rresp  = rs;
      s_if.rlast  = rl;
      s_if.rid    = pid[w];
      if (w == 1) begin m1_if.rready = rr; m0_if.rready = lr; end
      else        begin m0_if.rready = rr; m1_if.rready = lr; end
      if (allow_new && !pend[l] && $urandom_range(0, 7) == 0) begin
        new_req(l);
        drive_ar();
      end
      if (it == 1) begin
        wa = {$urandom, $urandom};
        wd = {$urandom, $urandom};
        m1w_if.awaddr  = wa;
        m1w_if.awvalid = 1'b1;
        m1w_if.wdata   = wd;
        m1w_if.wstrb   = 8'hFF;
        m1w_if.wlast   = 1'b1;
        m1w_if.wvalid  = 1'b1;
        m1w_if.bready  = rr;
        sw_if.awready  = lr;
        sw_if.wready   = rv;
        sw_if.bresp    = rs;
        sw_if.bvalid   = 1'b1;
      end
      #1;
      chk("data_gnt", 64'(gnt), (w == 1) ? 64'd2 : 64'd1);
      chk("data_win_rvalid", 64'((w == 1) ? m1_if.rvalid : m0_if.rvalid), 64'(rv));
      chk("data_win_rdata", (w == 1) ? m1_if.rdata : m0_if.rdata, dat);
      chk("data_win_rlast", 64'((w == 1) ? m1_if.rlast : m0_if.rlast), 64'(rl));
      chk("data_win_rresp", 64'((w == 1) ? m1_if.rresp : m0_if.rresp), 64'(rs));
      chk("data_lose_rvalid", 64'((l == 1) ? m1_if.rvalid : m0_if.rvalid), 64'd0);
      chk("data_lose_rdata", (l == 1) ? m1_if.rdata : m0_if.rdata, 64'd0);
      chk("data_s_rready", 64'(s_if.rready), 64'(rr));
      chk("data_s_arvalid", 64'(s_if.arvalid), 64'd0);
      chk("data_lose_arready", 64'((l == 1) ? m1_if.arready : m0_if.arready), 64'd0);
      if (it == 1) begin
        chk("wr_awaddr", sw_if.awaddr, wa);
        chk("wr_wdata", sw_if.wdata, wd);
        chk("wr_awready", 64'(m1w_if.awready), 64'(lr));
        chk("wr_wready", 64'(m1w_if.wready), 64'(rv));
        chk("wr_bresp", 64'(m1w_if.bresp), 64'(rs));
        chk("wr_bready", 64'(sw_if.bready), 64'(rr));
      end
      if (rv && rr) cnt++;
      @(negedge ACLK);
    end
    chk("burst_beats", 64'(cnt), 64'(lenw + 1));
    s_if.rvalid = 1'b0;
    last_w = w;
  endtask

  initial begin
    // quiet initial values for every bench-driven signal
    pend[0] = 0; pend[1] = 0;
    paddr[0] = '0; paddr[1] = '0; plen[0] = '0; plen[1] = '0; pid[0] = 0; pid[1] = 0;
    drive_ar();
    m0_if.arsize = 3'd2; m0_if.arburst = 2'd1; m0_if.arcache = 4'd0; m0_if.arprot = 3'd0; m0_if.arqos = 4'd0;
    m1_if.arsize = 3'd3; m1_if.arburst = 2'd1; m1_if.arcache = 4'd0; m1_if.arprot = 3'd0; m1_if.arqos = 4'd0;
    m0_if.rready = 1'b0; m1_if.rready = 1'b0;
    s_if.arready = 1'b0; s_if.rid = '0; s_if.rdata = '0; s_if.rresp = '0; s_if.rlast = 1'b0;
    s_if.rvalid = 1'b1;
    m1w_if.awid = '0; m1w_if.awaddr = '0; m1w_if.awlen = '0; m1w_if.awsize = 3'd3; m1w_if.awburst = 2'd1;
    m1w_if.awcache = '0; m1w_if.awprot = '0; m1w_if.awqos = '0; m1w_if.awvalid = 1'b0;
    m1w_if.wdata = '0; m1w_if.wstrb = '0; m1w_if.wlast = 1'b0; m1w_if.wvalid = 1'b0; m1w_if.bready = 1'b0;
    sw_if.awready = 1'b0; sw_if.wready = 1'b0; sw_if.bid = '0; sw_if.bresp = '0; sw_if.bvalid = 1'b0;

    // reset state
    repeat (3) @(negedge ACLK);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_s_arvalid", 64'(s_if.arvalid), 64'd0);
    chk("rst_s_rready", 64'(s_if.rready), 64'd0);
    chk("rst_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
    ARESETN = 1'b1;
    s_if.rvalid = 1'b0;

    // M0 alone: 0x8000_0000, two beats
    pend[0] = 1'b1; paddr[0] = 64'h0000_0000_8000_0000; plen[0] = 8'd1; pid[0] = 1'b0;
    do_round(1'b0, -1);

    // four simultaneous single-beat requests
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) new_req(0);
      if (!pend[1]) new_req(1);
      plen[0] = 8'd0; plen[1] = 8'd0;
      do_round(1'b0, 0);
    end
    while (pend[0] || pend[1]) do_round(1'b0, -1);

    // M1 burst interrupted by asynchronous reset during its first beat
    pend[1] = 1'b1; paddr[1] = 64'h0000_0000_8000_0200; plen[1] = 8'd1; pid[1] = 1'b1;
    drive_ar();
    s_if.arready = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    pend[1] = 1'b0; drive_ar(); s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rlast = 1'b0; s_if.rdata = 64'h1234_5678_9ABC_DEF0; m1_if.rready = 1'b1;
    m1w_if.awvalid = 1'b1;
    #1;
    chk("pre_rst_m1_rvalid", 64'(m1_if.rvalid), 64'd1);
    chk("pre_rst_gnt", 64'(gnt), 64'd2);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_gnt", 64'(gnt), 64'd0);
    chk("arst_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
    chk("arst_m1_rdata", m1_if.rdata, 64'd0);
    chk("arst_s_rready", 64'(s_if.rready), 64'd0);
    chk("arst_s_arvalid", 64'(s_if.arvalid), 64'd0);
    chk("arst_wr_awvalid", 64'(sw_if.awvalid), 64'd1);
    @(negedge ACLK);
    ARESETN = 1'b1;
    s_if.rvalid = 1'b0;
    last_w = 1;

    // M0 granted right after release
    pend[0] = 1'b1; paddr[0] = 64'h0000_0000_8000_0040; plen[0] = 8'd0; pid[0] = 1'b0;
    do_round(1'b0, -1);

    // M1 wins with both pending, slave holds arready low three cycles
    pend[0] = 1'b1; pend[1] = 1'b1; plen[1] = 8'd1;
    paddr[1] = 64'h0000_0000_8000_0300;
    do_round(1'b0, 3);
    while (pend[0] || pend[1]) do_round(1'b0, -1);

    // randomized traffic including mid-burst requests
    repeat (40) do_round(1'b1, -1);
    while (pend[0] || pend[1]) do_round(1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
